// File: rtl/counter_bank_if.sv
// Request/status bundle for counter_bank. The master side drives the per-channel
// controls and rates. The slave side (the counter bank) returns the registered
// counts and event flags. Channel n occupies slice [n*BIT_WIDTH +: BIT_WIDTH]
// of the packed vectors and bit [n] of the per-channel bit vectors.
interface counter_bank_if #(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 4
);
    logic [CHANNELS-1:0]           clear_en_i;
    logic [CHANNELS-1:0]           init_en_i;
    logic [CHANNELS-1:0]           counter_en_i;
    logic [CHANNELS-1:0]           decay_en_i;
    logic [CHANNELS-1:0]           saturate_en_i;
    logic [CHANNELS*BIT_WIDTH-1:0] seed_i;
    logic [CHANNELS*BIT_WIDTH-1:0] growth_rate_i;
    logic [CHANNELS*BIT_WIDTH-1:0] decay_rate_i;
    logic [CHANNELS*BIT_WIDTH-1:0] limit_i;
    logic [CHANNELS*BIT_WIDTH-1:0] count_o;
    logic [CHANNELS-1:0]           wrap_o;
    logic [CHANNELS-1:0]           clip_o;
    logic [CHANNELS-1:0]           overflow_o;

    modport master (
        output clear_en_i, init_en_i, counter_en_i, decay_en_i, saturate_en_i,
        output seed_i, growth_rate_i, decay_rate_i, limit_i,
        input  count_o, wrap_o, clip_o, overflow_o
    );

    modport slave (
        input  clear_en_i, init_en_i, counter_en_i, decay_en_i, saturate_en_i,
        input  seed_i, growth_rate_i, decay_rate_i, limit_i,
        output count_o, wrap_o, clip_o, overflow_o
    );
endinterface

// File: rtl/counter_bank.sv
// Multi-channel up/down counter bank. Each channel has a programmable limit,
// wrap or saturate behaviour, one-cycle wrap/clip event pulses and a sticky
// overflow flag. All outputs are registered.

package common_p;
    // Clock-domain bundle: the clock, its cycle qualifier and a synchronous
    // active-high reset.
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_dom_s;
endpackage

module counter_bank #(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 4
) (
    input common_p::clk_dom_s clk_dom_i,
    counter_bank_if.slave     bus_if
);

    typedef logic [BIT_WIDTH-1:0] cnt_t;
    // One extra bit so that count+rate and count+limit+1 never truncate.
    typedef logic [BIT_WIDTH:0]   ext_t;

    typedef struct packed {
        cnt_t count;
        logic wrap;
        logic clip;
    } step_t;

    logic [CHANNELS*BIT_WIDTH-1:0] count_q, count_d;
    logic [CHANNELS-1:0]           wrap_q, wrap_d;
    logic [CHANNELS-1:0]           clip_q, clip_d;
    logic [CHANNELS-1:0]           overflow_q, overflow_d;
    step_t                         step_res [CHANNELS];

    // One counting step for a single channel. Rates are clamped to the limit,
    // and a count left above a lowered limit is pulled back into range first.
    function automatic step_t step_channel(
        input cnt_t count,
        input cnt_t limit,
        input cnt_t growth,
        input cnt_t decay,
        input logic down,
        input logic sat
    );
        step_t res;
        ext_t  cnt;
        ext_t  lim;
        ext_t  g;
        ext_t  d;
        ext_t  sum;
        cnt = {1'b0, count};
        lim = {1'b0, limit};
        g   = (growth < limit) ? {1'b0, growth} : lim;
        d   = (decay  < limit) ? {1'b0, decay}  : lim;
        sum = cnt + g;
        res = '{count: count, wrap: 1'b0, clip: 1'b0};
        if (cnt > lim) begin
            if (sat) res = '{count: limit, wrap: 1'b0, clip: 1'b1};
            else     res = '{count: '0,    wrap: 1'b1, clip: 1'b0};
        end else if (!down) begin
            if (sum <= lim) res.count = cnt_t'(sum);
            else if (sat)   res = '{count: limit, wrap: 1'b0, clip: 1'b1};
            else            res = '{count: cnt_t'(sum - lim - ext_t'(1)), wrap: 1'b1, clip: 1'b0};
        end else begin
            if (d <= cnt)   res.count = cnt_t'(cnt - d);
            else if (sat)   res = '{count: '0, wrap: 1'b0, clip: 1'b1};
            else            res = '{count: cnt_t'(cnt + lim + ext_t'(1) - d), wrap: 1'b1, clip: 1'b0};
        end
        return res;
    endfunction

    // Candidate counting-step result for every channel.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            step_res[n] = step_channel(
                count_q[n*BIT_WIDTH +: BIT_WIDTH],
                bus_if.limit_i[n*BIT_WIDTH +: BIT_WIDTH],
                bus_if.growth_rate_i[n*BIT_WIDTH +: BIT_WIDTH],
                bus_if.decay_rate_i[n*BIT_WIDTH +: BIT_WIDTH],
                bus_if.decay_en_i[n],
                bus_if.saturate_en_i[n]);
        end
    end

    // Per-channel action select: clear > init > count > hold, all gated by clk_en.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        count_d    = count_q;
        wrap_d     = '0;
        clip_d     = '0;
        overflow_d = overflow_q;
        if (clk_dom_i.clk_en) begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (bus_if.clear_en_i[n]) begin
                    count_d[n*BIT_WIDTH +: BIT_WIDTH] = '0;
                    overflow_d[n]                     = 1'b0;
                end else if (bus_if.init_en_i[n]) begin
                    count_d[n*BIT_WIDTH +: BIT_WIDTH] =
                        (bus_if.seed_i[n*BIT_WIDTH +: BIT_WIDTH] < bus_if.limit_i[n*BIT_WIDTH +: BIT_WIDTH])
                        ? bus_if.seed_i[n*BIT_WIDTH +: BIT_WIDTH]
                        : bus_if.limit_i[n*BIT_WIDTH +: BIT_WIDTH];
                    overflow_d[n] = 1'b0;
                end else if (bus_if.counter_en_i[n]) begin
                    count_d[n*BIT_WIDTH +: BIT_WIDTH] = step_res[n].count;
                    wrap_d[n]     = step_res[n].wrap;
                    clip_d[n]     = step_res[n].clip;
                    overflow_d[n] = overflow_q[n] | step_res[n].wrap | step_res[n].clip;
                end
            end
        end
    end

    // State registers with synchronous reset. Pulses are reloaded every edge.
    always_ff @(posedge clk_dom_i.clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values and simulation matches hardware.
        if (clk_dom_i.sync_rst) begin
            count_q    <= '0;
            wrap_q     <= '0;
            clip_q     <= '0;
            overflow_q <= '0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            clip_q     <= clip_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus_if.count_o    = count_q;
    assign bus_if.wrap_o     = wrap_q;
    assign bus_if.clip_o     = clip_q;
    assign bus_if.overflow_o = overflow_q;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank (BIT_WIDTH=8, CHANNELS=4). Each applied
// vector pushes its hand-derived expected outputs to a scoreboard queue, which
// is popped and compared one clock later.
module tb_counter_bank;

    typedef struct {
        string       name;
        logic        clk_en;
        logic        rst;
        logic [3:0]  clr;
        logic [3:0]  ini;
        logic [3:0]  cen;
        logic [3:0]  dec;
        logic [3:0]  sat;
        logic [31:0] seed;
        logic [31:0] grow;
        logic [31:0] decay;
        logic [31:0] limit;
        logic [31:0] exp_count;
        logic [3:0]  exp_wrap;
        logic [3:0]  exp_clip;
        logic [3:0]  exp_ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] count;
        logic [3:0]  wrap;
        logic [3:0]  clip;
        logic [3:0]  ovf;
    } exp_t;

    logic clk;
    logic clk_en;
    logic sync_rst;
    common_p::clk_dom_s clk_dom;

    int n_checks;
    int n_errors;
    exp_t sb[$];
    vec_t vecs[26];

    counter_bank_if #(.BIT_WIDTH(8), .CHANNELS(4)) bus ();

    assign clk_dom = '{clk: clk, clk_en: clk_en, sync_rst: sync_rst};

    counter_bank #(.BIT_WIDTH(8), .CHANNELS(4)) dut (
        .clk_dom_i (clk_dom),
        .bus_if    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: no expected entry, got count %h", bus.count_o);
        end else begin
            e = sb.pop_front();
            check({e.name, ".count"},    bus.count_o,    e.count);
            check({e.name, ".wrap"},     bus.wrap_o,     e.wrap);
            check({e.name, ".clip"},     bus.clip_o,     e.clip);
            check({e.name, ".overflow"}, bus.overflow_o, e.ovf);
        end
    endtask

    task automatic apply(input vec_t v);
        clk_en               = v.clk_en;
        sync_rst             = v.rst;
        bus.clear_en_i       = v.clr;
        bus.init_en_i        = v.ini;
        bus.counter_en_i     = v.cen;
        bus.decay_en_i       = v.dec;
        bus.saturate_en_i    = v.sat;
        bus.seed_i           = v.seed;
        bus.growth_rate_i    = v.grow;
        bus.decay_rate_i     = v.decay;
        bus.limit_i          = v.limit;
        sb.push_back('{name: v.name, count: v.exp_count, wrap: v.exp_wrap,
                       clip: v.exp_clip, ovf: v.exp_ovf});
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        vec_t h;
        n_checks = 0;
        n_errors = 0;

        //              name            ce   rst  clr   ini   cen   dec   sat   seed          grow          decay         limit         exp_count     w     c     ovf
        vecs[0]  = '{"rst_init",     1'b1,1'b1,4'h0,4'h0,4'h0,4'h0,4'h0,32'h00000000,32'h00000000,32'h00000000,32'hFFFFFFFF,32'h00000000,4'h0,4'h0,4'h0};
        vecs[1]  = '{"init37",       1'b1,1'b0,4'h0,4'h1,4'h0,4'h0,4'h0,32'h00000025,32'h00000000,32'h00000000,32'hFFFFFFFF,32'h00000025,4'h0,4'h0,4'h0};
        vecs[2]  = '{"rst_noce",     1'b0,1'b1,4'h0,4'h0,4'hF,4'h0,4'h0,32'h00000000,32'h01010101,32'h00000000,32'hFFFFFFFF,32'h00000000,4'h0,4'h0,4'h0};
        vecs[3]  = '{"wrap_init",    1'b1,1'b0,4'h0,4'h1,4'h0,4'h0,4'h0,32'h00000007,32'h00000000,32'h00000000,32'hFFFFFF09,32'h00000007,4'h0,4'h0,4'h0};
        vecs[4]  = '{"wrap_s1",      1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h0,32'h00000000,32'h00000002,32'h00000000,32'hFFFFFF09,32'h00000009,4'h0,4'h0,4'h0};
        vecs[5]  = '{"wrap_s2",      1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h0,32'h00000000,32'h00000002,32'h00000000,32'hFFFFFF09,32'h00000001,4'h1,4'h0,4'h1};
        vecs[6]  = '{"wrap_hold",    1'b1,1'b0,4'h0,4'h0,4'h0,4'h0,4'h0,32'h00000000,32'h00000002,32'h00000000,32'hFFFFFF09,32'h00000001,4'h0,4'h0,4'h1};
        vecs[7]  = '{"wrap_reinit",  1'b1,1'b0,4'h0,4'h1,4'h0,4'h0,4'h0,32'h00000007,32'h00000000,32'h00000000,32'hFFFFFF09,32'h00000007,4'h0,4'h0,4'h0};
        vecs[8]  = '{"sat_init",     1'b1,1'b0,4'h0,4'h2,4'h0,4'h0,4'h0,32'h00000500,32'h00000000,32'h00000000,32'hFFFFFF09,32'h00000507,4'h0,4'h0,4'h0};
        vecs[9]  = '{"sat_d1",       1'b1,1'b0,4'h0,4'h0,4'h2,4'h2,4'h2,32'h00000000,32'h00000000,32'h00000300,32'hFFFFFF09,32'h00000207,4'h0,4'h0,4'h0};
        vecs[10] = '{"sat_d2",       1'b1,1'b0,4'h0,4'h0,4'h2,4'h2,4'h2,32'h00000000,32'h00000000,32'h00000300,32'hFFFFFF09,32'h00000007,4'h0,4'h2,4'h2};
        vecs[11] = '{"sat_d3",       1'b1,1'b0,4'h0,4'h0,4'h2,4'h2,4'h2,32'h00000000,32'h00000000,32'h00000300,32'hFFFFFF09,32'h00000007,4'h0,4'h2,4'h2};
        vecs[12] = '{"sat_idle",     1'b1,1'b0,4'h0,4'h0,4'h0,4'h2,4'h2,32'h00000000,32'h00000000,32'h00000300,32'hFFFFFF09,32'h00000007,4'h0,4'h0,4'h2};
        vecs[13] = '{"pri_init",     1'b1,1'b0,4'h0,4'h4,4'h0,4'h0,4'h0,32'h00FF0000,32'h00000000,32'h00000000,32'hFFFFFF09,32'h00FF0007,4'h0,4'h0,4'h2};
        vecs[14] = '{"pri_clip",     1'b1,1'b0,4'h0,4'h0,4'h4,4'h0,4'h4,32'h00000000,32'h00010000,32'h00000000,32'hFFFFFF09,32'h00FF0007,4'h0,4'h4,4'h6};
        vecs[15] = '{"pri_clr",      1'b1,1'b0,4'h4,4'h4,4'h4,4'h0,4'h0,32'h00140000,32'h00010000,32'h00000000,32'hFFFFFF09,32'h00000007,4'h0,4'h0,4'h2};
        vecs[16] = '{"pri_init_cnt", 1'b1,1'b0,4'h0,4'h4,4'h4,4'h4,4'h0,32'h00140000,32'h00000000,32'h00050000,32'hFFFFFF09,32'h00140007,4'h0,4'h0,4'h2};
        vecs[17] = '{"rc_clr",       1'b1,1'b0,4'h1,4'h0,4'h0,4'h0,4'h0,32'h00000000,32'h00000000,32'h00000000,32'hFFFFFF04,32'h05140000,4'h0,4'h0,4'h2};
        vecs[18] = '{"rc_s1",        1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h0,32'h00000000,32'h0000000A,32'h00000000,32'hFFFFFF04,32'h05140004,4'h0,4'h0,4'h2};
        vecs[19] = '{"rc_s2",        1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h0,32'h00000000,32'h0000000A,32'h00000000,32'hFFFFFF04,32'h05140003,4'h1,4'h0,4'h3};
        vecs[20] = '{"rc_lim2",      1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h0,32'h00000000,32'h0000000A,32'h00000000,32'hFFFFFF02,32'h05140000,4'h1,4'h0,4'h3};
        vecs[21] = '{"rc_init3",     1'b1,1'b0,4'h0,4'h1,4'h0,4'h0,4'h0,32'h00000003,32'h00000000,32'h00000000,32'hFFFFFF04,32'h05140003,4'h0,4'h0,4'h2};
        vecs[22] = '{"rc_sat_lim2",  1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h1,32'h00000000,32'h0000000A,32'h00000000,32'hFFFFFF02,32'h05140002,4'h0,4'h1,4'h3};
        vecs[23] = '{"rc_sat_bound", 1'b1,1'b0,4'h0,4'h0,4'h1,4'h0,4'h1,32'h00000000,32'h0000000A,32'h00000000,32'hFFFFFF02,32'h05140002,4'h0,4'h1,4'h3};
        vecs[24] = '{"wrap_down",    1'b1,1'b0,4'h0,4'h0,4'h2,4'h2,4'h0,32'h00000000,32'h00000000,32'h00000300,32'hFFFFFF02,32'h0514FD02,4'h2,4'h0,4'h3};
        vecs[25] = '{"rst_mid",      1'b1,1'b1,4'h0,4'h0,4'hF,4'h0,4'h0,32'h00000000,32'h01010101,32'h00000000,32'hFFFFFF02,32'h00000000,4'h0,4'h0,4'h0};

        // Reset, wrap-up, saturating-down and priority cases.
        for (int i = 0; i <= 16; i++) apply(vecs[i]);

        // Gating: clk_en low with every channel requesting a step freezes all state.
        for (int k = 0; k < 3; k++) begin
            h = '{"gate_off", 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 32'h0,
                  32'h01010101, 32'h0, 32'hFFFFFF09, 32'h00140007, 4'h0, 4'h0, 4'h2};
            apply(h);
        end

        // Independence: only ch3 steps, while every channel sees growth 1.
        for (int k = 1; k <= 5; k++) begin
            h = '{"ch3_only", 1'b1, 1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 32'h0,
                  32'h01010101, 32'h0, 32'hFFFFFF09, 32'h00140007 | (k << 24),
                  4'h0, 4'h0, 4'h2};
            apply(h);
        end

        // Rate clamping, runtime limit lowering, down-wrap and mid-run reset.
        for (int i = 17; i <= 25; i++) apply(vecs[i]);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
